mem_stage: RTL
==============

# mem_stage
Memory-access pipeline stage between EX and WB. Registers the EX-to-MEM handover and waits for the outstanding `data_sram` response when EX issued a request. It extracts and sign/zero-extends load data and selects the final result (load, multiplier or ALU). It also drops late responses that belong to flushed instructions, and drives hazard information to ID and store suppression to EX.
## Interface
- Parameters: none.
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- ex_valid  in  1  EX has a valid instruction with ready_go (handover offered)
- ex_wait_data_ok  in  1  EX issued a data_sram request for this instruction
- ex_ld_ctrl  in  5  one-hot load type {ld_w, ld_bu, ld_b, ld_hu, ld_h}
- ex_res_from_mem  in  1  result comes from memory (already 0 on ALE)
- ex_mul  in  1  result comes from multiplier
- ex_result  in  32  ALU/div/counter result; for memory ops, the byte address
- mul_result  in  32  multiplier output, valid during the MEM cycle of the instruction
- ex_rf_we  in  1  register write enable
- ex_rf_waddr  in  5  destination register
- ex_pc  in  32  instruction PC
- ex_ebus  in  16  accumulated exception bits
- data_sram_data_ok  in  1  response strobe
- data_sram_rdata  in  32  response data, valid with data_ok
- flush  in  1  exception/ertn flush from WB; kills MEM contents
- wb_allow_in  in  1  WB can accept
- mem_allow_in  out  1  MEM can accept from EX
- mem_exc  out  1  valid & |ebus; EX uses this as st_disable
- wb_valid  out  1  MEM hands an instruction to WB this cycle (valid & ready_go & ~flush)
- wb_rf_we  out  1  valid & rf_we (also the bypass write enable)
- wb_rf_waddr  out  5  destination register (also the bypass address)
- wb_result  out  32  final result (also the bypass data)
- wb_pc  out  32  PC
- wb_ebus  out  16  exception bits
- byp_stall  out  1  ID must stall a consumer of wb_rf_waddr; result not yet available
## Operation
- Capture: on `ex_valid & mem_allow_in`, all ex_* fields are registered and valid←1. Otherwise, if `wb_allow_in & ready_go` or flush, valid←0.
- `mem_allow_in = ~valid | (ready_go & wb_allow_in)`.
- `ready_go = ~wait | got | (data_ok & discard==0)`. `got` means data is held in the response buffer.
- Response buffer (rbuf, got): on `data_ok & discard==0 & valid & wait & ~got` while the instruction does not leave this cycle: rbuf←rdata, got←1. got←0 when the instruction leaves or on flush. rdata_sel = got ? rbuf : data_sram_rdata.
- Discard counter (2 bits): +1 on `flush & valid & wait & ~got & ~data_ok`. -1 on `data_ok & discard!=0`. Both events in the same cycle leave it unchanged. A data_ok consumed by the counter is never delivered. The counter saturates at 3.
- Load extraction by addr[1:0] = ex_result[1:0]: byte = rdata_sel[8*a+7:8*a]; half = a[1] ? [31:16] : [15:0]. ld_b/ld_h sign-extend, ld_bu/ld_hu zero-extend, ld_w passes through.
- `wb_result = res_from_mem ? load_data : mul ? mul_result : ex_result`.
- byp_stall = valid & res_from_mem & ~ready_go (see Configuration).
- With flush asserted, wb_valid=0 and mem_exc=0 in that cycle.
## Timing
- Reset values: valid=0, got=0, discard=0, rbuf=0, all registered fields 0. Hence wb_valid=0, wb_rf_we=0, mem_exc=0, byp_stall=0, mem_allow_in=1.
- EX→MEM latency is 1 cycle. A response arriving in the capture+1 cycle with wb_allow_in=1 is handed to WB in that same cycle (0 extra cycles).
- A response arriving while wb_allow_in=0 is buffered; the handover occurs in the first cycle with wb_allow_in=1.
- After a flush with a pending response, a new load entering MEM stalls (ready_go=0) until discard returns to 0, and only the following data_ok is delivered.
- Reset mid-operation clears valid, got and discard in the same edge; no output depends on pre-reset state afterwards.
## Configuration
- `MEM_LOAD_BYPASS_EN` defined: byp_stall = valid & res_from_mem & ~ready_go. Returned load data is forwarded to ID in the data_ok cycle.
- Not defined: byp_stall = valid & res_from_mem. Loads are never forwarded from MEM; consumers wait for WB.
## Test plan
- Load ld_b from address 0x...3, rdata=0x80FF_0000, data_ok one cycle after capture, wb_allow_in=1 → wb_result=0xFFFF_FF80 and wb_valid=1 in the data_ok cycle.
- ld_hu from address 0x...2, rdata=0x8001_1234, data_ok arrives while wb_allow_in=0 for 3 cycles → buffered, and wb_result=0x0000_8001 on the first cycle with wb_allow_in=1.
- Load waiting on data_ok, flush asserted → discard=1. The next load is captured; the first data_ok (0xDEAD_BEEF) is dropped, the second (0x1234_5678, ld_w) yields wb_result=0x1234_5678.
- flush and data_ok in the same cycle → discard stays 0 and the next instruction's response is delivered normally.
- ex_mul=1 with mul_result=0x0000_0006 → wb_result=6. Instruction with ex_ebus≠0 → mem_exc=1 and wb_ebus matches ex_ebus.
- Configuration check: with the macro undefined, a load in MEM with data_ok present → byp_stall=1. With the macro defined → byp_stall=0 in the same stimulus.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between EX and WB.
// Registers the EX->MEM handover, waits for the data_sram response of a load/store,
// extracts and extends load data, and selects the final result (load, mul or ALU).
// Responses that belong to flushed instructions are counted and dropped.
//
// Configuration macro: MEM_LOAD_BYPASS_EN
//   defined   : byp_stall = valid & res_from_mem & ~ready_go (load data forwarded on data_ok)
//   undefined : byp_stall = valid & res_from_mem (loads never forwarded from MEM)
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   ex_*                  instruction fields offered by EX (ex_valid = handover offered)
//   mul_result            multiplier output during the instruction's MEM cycle
//   data_sram_data_ok/_rdata  response strobe and data
//   flush                 kills MEM contents
//   wb_allow_in           WB can accept
//   mem_allow_in          MEM can accept from EX
//   mem_exc               store suppression to EX
//   wb_*                  handover to WB (also the bypass path)
//   byp_stall             ID must stall a consumer of wb_rf_waddr
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic        ex_wait_data_ok,
  input  logic [4:0]  ex_ld_ctrl,
  input  logic        ex_res_from_mem,
  input  logic        ex_mul,
  input  logic [31:0] ex_result,
  input  logic [31:0] mul_result,
  input  logic        ex_rf_we,
  input  logic [4:0]  ex_rf_waddr,
  input  logic [31:0] ex_pc,
  input  logic [15:0] ex_ebus,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  input  logic        flush,
  input  logic        wb_allow_in,
  output logic        mem_allow_in,
  output logic        mem_exc,
  output logic        wb_valid,
  output logic        wb_rf_we,
  output logic [4:0]  wb_rf_waddr,
  output logic [31:0] wb_result,
  output logic [31:0] wb_pc,
  output logic [15:0] wb_ebus,
  output logic        byp_stall
);

  logic        valid_q, valid_d;
  logic        wait_q, wait_d;
  logic [4:0]  ld_ctrl_q, ld_ctrl_d;
  logic        res_from_mem_q, res_from_mem_d;
  logic        mul_q, mul_d;
  logic [31:0] result_q, result_d;
  logic        rf_we_q, rf_we_d;
  logic [4:0]  rf_waddr_q, rf_waddr_d;
  logic [31:0] pc_q, pc_d;
  logic [15:0] ebus_q, ebus_d;
  logic        got_q, got_d;
  logic [31:0] rbuf_q, rbuf_d;
  logic [1:0]  discard_q, discard_d;

  logic        ready_go;
  logic        leaving;
  logic        capture;
  logic        disc_inc;
  logic        disc_dec;
  logic [31:0] rdata_sel;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_data;

  // A data_ok is ours only when no flushed response is still outstanding.
  assign ready_go     = ~wait_q | got_q | (data_sram_data_ok & (discard_q == 2'd0));
  assign mem_allow_in = ~valid_q | (ready_go & wb_allow_in);
  assign wb_valid     = valid_q & ready_go & ~flush;
  assign leaving      = wb_valid & wb_allow_in;
  assign capture      = ex_valid & mem_allow_in;
  assign mem_exc      = valid_q & (|ebus_q) & ~flush;
  assign wb_rf_we     = valid_q & rf_we_q;
  assign wb_rf_waddr  = rf_waddr_q;
  assign wb_pc        = pc_q;
  assign wb_ebus      = ebus_q;

  assign disc_inc = flush & valid_q & wait_q & ~got_q & ~data_sram_data_ok &
                    (discard_q != 2'd3);
  assign disc_dec = data_sram_data_ok & (discard_q != 2'd0);

  always_comb begin
    valid_d        = valid_q;
    wait_d         = wait_q;
    ld_ctrl_d      = ld_ctrl_q;
    res_from_mem_d = res_from_mem_q;
    mul_d          = mul_q;
    result_d       = result_q;
    rf_we_d        = rf_we_q;
    rf_waddr_d     = rf_waddr_q;
    pc_d           = pc_q;
    ebus_d         = ebus_q;
    got_d          = got_q;
    rbuf_d         = rbuf_q;
    discard_d      = discard_q;

    if (capture) begin
      valid_d        = 1'b1;
      wait_d         = ex_wait_data_ok;
      ld_ctrl_d      = ex_ld_ctrl;
      res_from_mem_d = ex_res_from_mem;
      mul_d          = ex_mul;
      result_d       = ex_result;
      rf_we_d        = ex_rf_we;
      rf_waddr_d     = ex_rf_waddr;
      pc_d           = ex_pc;
      ebus_d         = ex_ebus;
    end else if ((wb_allow_in & ready_go) | flush) begin
      valid_d = 1'b0;
    end

    // Hold a response that arrives while WB cannot take the instruction.
    if (flush | leaving) begin
      got_d = 1'b0;
    end else if (data_sram_data_ok & (discard_q == 2'd0) & valid_q & wait_q & ~got_q) begin
      got_d  = 1'b1;
      rbuf_d = data_sram_rdata;
    end

    if (disc_inc & ~disc_dec) begin
      discard_d = discard_q + 2'd1;
    end else if (disc_dec & ~disc_inc) begin
      discard_d = discard_q - 2'd1;
    end
  end

  assign rdata_sel = got_q ? rbuf_q : data_sram_rdata;

  always_comb begin
    case (result_q[1:0])
      2'd0:    byte_v = rdata_sel[7:0];
      2'd1:    byte_v = rdata_sel[15:8];
      2'd2:    byte_v = rdata_sel[23:16];
      default: byte_v = rdata_sel[31:24];
    endcase
    half_v = result_q[1] ? rdata_sel[31:16] : rdata_sel[15:0];

    // ld_ctrl = {ld_w, ld_bu, ld_b, ld_hu, ld_h}
    case (ld_ctrl_q)
      5'b01000: load_data = {24'd0, byte_v};
      5'b00100: load_data = {{24{byte_v[7]}}, byte_v};
      5'b00010: load_data = {16'd0, half_v};
      5'b00001: load_data = {{16{half_v[15]}}, half_v};
      default:  load_data = rdata_sel;
    endcase

    if (res_from_mem_q) begin
      wb_result = load_data;
    end else if (mul_q) begin
      wb_result = mul_result;
    end else begin
      wb_result = result_q;
    end
  end

`ifdef MEM_LOAD_BYPASS_EN
  assign byp_stall = valid_q & res_from_mem_q & ~ready_go;
`else
  assign byp_stall = valid_q & res_from_mem_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q        <= 1'b0;
      wait_q         <= 1'b0;
      ld_ctrl_q      <= 5'd0;
      res_from_mem_q <= 1'b0;
      mul_q          <= 1'b0;
      result_q       <= 32'd0;
      rf_we_q        <= 1'b0;
      rf_waddr_q     <= 5'd0;
      pc_q           <= 32'd0;
      ebus_q         <= 16'd0;
      got_q          <= 1'b0;
      rbuf_q         <= 32'd0;
      discard_q      <= 2'd0;
    end else begin
      valid_q        <= valid_d;
      wait_q         <= wait_d;
      ld_ctrl_q      <= ld_ctrl_d;
      res_from_mem_q <= res_from_mem_d;
      mul_q          <= mul_d;
      result_q       <= result_d;
      rf_we_q        <= rf_we_d;
      rf_waddr_q     <= rf_waddr_d;
      pc_q           <= pc_d;
      ebus_q         <= ebus_d;
      got_q          <= got_d;
      rbuf_q         <= rbuf_d;
      discard_q      <= discard_d;
    end
  end

endmodule
